// File: rtl/bus_transceiver_sync.sv
// Clocked bidirectional bus transceiver: local d_in/d_out port <-> shared tri-state d_bus.
// Control pins are synchronised and every direction change passes through a released TURN phase.
module bus_transceiver_sync #(
   parameter int unsigned WIDTH       = 4,
   parameter int unsigned INVERT      = 0,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned TURNAROUND  = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cs_n,
   input  logic             dce,
   input  logic [WIDTH-1:0] d_in,
   output logic [WIDTH-1:0] d_out,
   output logic             d_out_en,
   output logic             d_out_stb,
   inout  wire  [WIDTH-1:0] d_bus,
   output logic             bus_oe,
   output logic             busy
);

   typedef enum logic [1:0] {StOff, StTurn, StDrive, StSample} state_e;

   localparam logic [WIDTH-1:0] InvMask  = (INVERT != 0) ? '1 : '0;
   localparam bit               HasTurn  = (TURNAROUND != 0);
   localparam logic [3:0]       TurnLast = (TURNAROUND == 0) ? 4'd0 : 4'(TURNAROUND - 1);

   logic cs_s, dce_s;

   generate
      if (SYNC_STAGES == 0) begin : g_nosync
         assign cs_s  = cs_n;
         assign dce_s = dce;
      end else begin : g_sync
         logic [SYNC_STAGES-1:0] cs_sync_q, dce_sync_q;

         // cs resets to 1 so the block stays detached until a real select is seen
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               cs_sync_q  <= '1;
               dce_sync_q <= '0;
            end else begin
               cs_sync_q  <= (cs_sync_q << 1) | SYNC_STAGES'(cs_n);
               dce_sync_q <= (dce_sync_q << 1) | SYNC_STAGES'(dce);
            end
         end

         assign cs_s  = cs_sync_q[SYNC_STAGES-1];
         assign dce_s = dce_sync_q[SYNC_STAGES-1];
      end
   endgenerate

   state_e           state_q, state_d;
   logic             tgt_q, tgt_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [WIDTH-1:0] d_in_q;
   logic [WIDTH-1:0] d_out_q, d_out_d;
   logic             bus_oe_q, d_out_en_q, d_out_stb_q, busy_q;

   // tgt: 0 = head for DRIVE, 1 = head for SAMPLE
   always_comb begin
      state_d = state_q;
      tgt_d   = tgt_q;
      cnt_d   = cnt_q;
      case (state_q)
         StOff: begin
            if (!cs_s) begin
               tgt_d   = dce_s;
               cnt_d   = 4'd0;
               state_d = HasTurn ? StTurn : (dce_s ? StSample : StDrive);
            end
         end
         StTurn: begin
            if (cs_s) begin
               state_d = StOff;
            end else if (dce_s != tgt_q) begin
               tgt_d = dce_s;
               cnt_d = 4'd0;
            end else if (cnt_q == TurnLast) begin
               state_d = tgt_q ? StSample : StDrive;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         StDrive: begin
            if (cs_s) begin
               state_d = StOff;
            end else if (dce_s) begin
               tgt_d   = 1'b1;
               cnt_d   = 4'd0;
               state_d = HasTurn ? StTurn : StSample;
            end
         end
         StSample: begin
            if (cs_s) begin
               state_d = StOff;
            end else if (!dce_s) begin
               tgt_d   = 1'b0;
               cnt_d   = 4'd0;
               state_d = HasTurn ? StTurn : StDrive;
            end
         end
         default: state_d = StOff;
      endcase
   end

   always_comb begin
      d_out_d = d_out_q;
      if (state_d == StSample) d_out_d = d_bus ^ InvMask;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StOff;
         tgt_q       <= 1'b0;
         cnt_q       <= 4'd0;
         d_in_q      <= '0;
         d_out_q     <= '0;
         bus_oe_q    <= 1'b0;
         d_out_en_q  <= 1'b0;
         d_out_stb_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         tgt_q       <= tgt_d;
         cnt_q       <= cnt_d;
         d_in_q      <= d_in;
         d_out_q     <= d_out_d;
         bus_oe_q    <= (state_d == StDrive);
         d_out_en_q  <= (state_d == StSample);
         d_out_stb_q <= (state_d == StSample) && (state_q != StSample);
         busy_q      <= (state_d == StTurn);
      end
   end

   assign d_bus     = bus_oe_q ? (d_in_q ^ InvMask) : {WIDTH{1'bz}};
   assign d_out     = d_out_q;
   assign d_out_en  = d_out_en_q;
   assign d_out_stb = d_out_stb_q;
   assign bus_oe    = bus_oe_q;
   assign busy      = busy_q;

endmodule
